// File: rtl/dpram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter_if
// Groups the signals of the two requesters and of the shared RAM port that
// the arbiter sits between.
//   Requester side : reqN, weN, addrN, wdataN (to arbiter)
//                    ackN, rvalidN, rdataN   (from arbiter)
//   RAM side       : ram_wren, ram_address, ram_data (from arbiter)
//                    ram_q                           (to arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the environment: both requesters plus the RAM port
// ---------------------------------------------------------------------------
interface dpram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
    output ram_wren, ram_address, ram_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
    input  ram_wren, ram_address, ram_data
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_port_arbiter
// Shares one synchronous port of a dual-port RAM between requester 0 (CPU)
// and requester 1 (DMA / video fetch). At most one request is issued per
// clock; the RAM has one cycle of read latency and the read result is
// registered once more before it is returned to its owner.
//
// Timing (E = edge at which the grant is registered):
//   E..E+1   issue cycle: ram_* driven from registers, ackN = 1
//   E+1      RAM samples address / write
//   E+2      ram_q captured into rdataN, rvalidN = 1 during E+2..E+3
//
// Ports:
//   clock_i    single clock, shared with the RAM port
//   reset_n_i  asynchronous assert, active low
//   bus        dpram_port_arbiter_if.slave (requesters + RAM port)
//
// Build option:
//   DPRAM_ARB_RR_EN  defined   - round-robin between requesters on contention
//                    undefined - strict priority, requester 0 always wins
// ---------------------------------------------------------------------------
module dpram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  dpram_port_arbiter_if.slave bus
);

  // Issue-slot state: which requester (if any) owns the RAM this cycle.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  // Requester inputs gathered into arrays so selection is a simple index.
  logic [1:0]        req_w;
  logic [1:0]        we_w;
  logic [ADDR_W-1:0] addr_w  [2];
  logic [DATA_W-1:0] wdata_w [2];

  assign req_w      = {bus.req1, bus.req0};
  assign we_w       = {bus.we1, bus.we0};
  assign addr_w[0]  = bus.addr0;
  assign addr_w[1]  = bus.addr1;
  assign wdata_w[0] = bus.wdata0;
  assign wdata_w[1] = bus.wdata1;

  logic [1:0]        state_q, state_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  // Read tag pipe: stage 1 = issue cycle, stage 2 = RAM output cycle.
  logic              tag1_vld_q, tag1_vld_d;
  logic              tag1_own_q, tag1_own_d;
  logic              tag2_vld_q;
  logic              tag2_own_q;

  logic [1:0]        elig_w;
  logic              grant_w;
  logic              gsel_w;

  // A requester acknowledged this cycle is not eligible again until the
  // next cycle, which is what lets a held request alternate with the other.
  assign elig_w[0] = req_w[0] & (state_q != ST_GRANT0);
  assign elig_w[1] = req_w[1] & (state_q != ST_GRANT1);
  assign grant_w   = |elig_w;

`ifdef DPRAM_ARB_RR_EN
  // rr_last holds the most recent winner; on contention the other one goes.
  logic rr_last_q, rr_last_d;

  assign gsel_w    = elig_w[1] & (~elig_w[0] | ~rr_last_q);
  assign rr_last_d = grant_w ? gsel_w : rr_last_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  assign gsel_w = elig_w[1] & ~elig_w[0];
`endif

  always_comb begin
    state_d    = ST_IDLE;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    tag1_vld_d = 1'b0;
    tag1_own_d = tag1_own_q;
    if (grant_w) begin
      state_d    = gsel_w ? ST_GRANT1 : ST_GRANT0;
      wren_d     = we_w[gsel_w];
      addr_d     = addr_w[gsel_w];
      data_d     = wdata_w[gsel_w];
      tag1_vld_d = ~we_w[gsel_w];
      tag1_own_d = gsel_w;
    end
  end

  // Reset clears wren_q asynchronously, so a write granted in the cycle in
  // which reset arrives never reaches the RAM.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tag1_vld_q <= 1'b0;
      tag1_own_q <= 1'b0;
      tag2_vld_q <= 1'b0;
      tag2_own_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag1_vld_q <= tag1_vld_d;
      tag1_own_q <= tag1_own_d;
      tag2_vld_q <= tag1_vld_q;
      tag2_own_q <= tag1_own_q;
    end
  end

  // Per-requester return path: only the tagged owner captures ram_q.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    logic              hit_w;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign hit_w   = tag2_vld_q & (tag2_own_q == 1'(gi));
    assign rdata_d = hit_w ? bus.ram_q : rdata_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= hit_w;
        rdata_q  <= rdata_d;
      end
    end
  end

  assign bus.ack0        = (state_q == ST_GRANT0);
  assign bus.ack1        = (state_q == ST_GRANT1);
  assign bus.ram_wren    = wren_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.rvalid0     = g_ret[0].rvalid_q;
  assign bus.rvalid1     = g_ret[1].rvalid_q;
  assign bus.rdata0      = g_ret[0].rdata_q;
  assign bus.rdata1      = g_ret[1].rdata_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dpram_port_arbiter
// Drives both requesters of dpram_port_arbiter against a behavioural RAM.
// A monitor predicts each cycle's grant from the arbitration rules, keeps a
// reference memory as an associative array, queues expected read returns
// per requester and checks them when rvalid appears. Directed sequences
// cover the named scenarios; a randomized phase follows.
// Build option DPRAM_ARB_RR_EN selects the round-robin expectations.
// ---------------------------------------------------------------------------
module tb_dpram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  // Requester drive variables.
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  assign bus.req0   = req[0];
  assign bus.req1   = req[1];
  assign bus.we0    = we[0];
  assign bus.we1    = we[1];
  assign bus.addr0  = addr[0];
  assign bus.addr1  = addr[1];
  assign bus.wdata0 = wdata[0];
  assign bus.wdata1 = wdata[1];

  // Behavioural synchronous RAM, read-old-data on a same-address write.
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] ram_q;
  assign bus.ram_q = ram_q;
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    ram_q <= mem[bus.ram_address];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          chk;
    int            due;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] ref_mem [int];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not as required (cycle %0d)", nm, cyc);
  endtask

  function automatic logic ack_of(input int n);
    return (n == 1) ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic rv_of(input int n);
    return (n == 1) ? bus.rvalid1 : bus.rvalid0;
  endfunction

  function automatic logic [DW-1:0] rd_of(input int n);
    return (n == 1) ? bus.rdata1 : bus.rdata0;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  task automatic monitor();
    logic [1:0]    p_req, p_ack, p_we, e;
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_rd [2];
    logic          rr_last;
    logic          rv;
    logic [DW-1:0] rd;
    int            g;
    exp_t          ent;
    p_req = '0; p_ack = '0; p_we = '0;
    p_addr = '{default: '0}; p_wdata = '{default: '0};
    last_addr = '0; last_rd = '{default: '0}; rr_last = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("reset_ctrl", {27'd0, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus.ram_wren}, 32'd0);
        check("reset_ram_addr", 32'(bus.ram_address), 32'd0);
        check("reset_ram_data", 32'(bus.ram_data), 32'd0);
        check("reset_rdata", {16'd0, bus.rdata0, bus.rdata1}, 32'd0);
        q0.delete(); q1.delete();
        p_req = '0; p_ack = '0; p_we = '0;
        last_addr = '0; last_rd = '{default: '0}; rr_last = 1'b1;
      end else begin
        e[0] = p_req[0] & ~p_ack[0];
        e[1] = p_req[1] & ~p_ack[1];
        if (e == 2'b11) begin
`ifdef DPRAM_ARB_RR_EN
          e = rr_last ? 2'b01 : 2'b10;
`else
          e = 2'b01;
`endif
        end
        check("ack", {30'd0, bus.ack1, bus.ack0}, {30'd0, e});
        if (e != 2'b00) begin
          g = e[1] ? 1 : 0;
          rr_last = e[1];
          last_addr = p_addr[g];
          check("ram_wren", {31'd0, bus.ram_wren}, {31'd0, p_we[g]});
          check("ram_address", 32'(bus.ram_address), 32'(p_addr[g]));
          if (p_we[g]) begin
            check("ram_data", 32'(bus.ram_data), 32'(p_wdata[g]));
            ref_mem[int'(p_addr[g])] = p_wdata[g];
            $display("txn cyc=%0d port=%0d write addr=0x%03h data=0x%02h", cyc, g, p_addr[g], p_wdata[g]);
          end else begin
            ent.chk  = ref_mem.exists(int'(p_addr[g]));
            ent.data = ent.chk ? ref_mem[int'(p_addr[g])] : '0;
            ent.due  = cyc + 2;
            if (g == 1) q1.push_back(ent); else q0.push_back(ent);
          end
        end else begin
          check("idle_wren", {31'd0, bus.ram_wren}, 32'd0);
          check("idle_addr_hold", 32'(bus.ram_address), 32'(last_addr));
        end
        for (int n = 0; n < 2; n++) begin
          rv = rv_of(n);
          rd = rd_of(n);
          if (rv) begin
            if ((n == 1 ? q1.size() : q0.size()) == 0) begin
              fail($sformatf("rvalid%0d_spurious", n));
            end else begin
              if (n == 1) ent = q1.pop_front(); else ent = q0.pop_front();
              check($sformatf("rvalid%0d_latency", n), 32'(cyc), 32'(ent.due));
              if (ent.chk) check($sformatf("rdata%0d", n), 32'(rd), 32'(ent.data));
              $display("txn cyc=%0d port=%0d read data=0x%02h", cyc, n, rd);
            end
            last_rd[n] = rd;
          end else begin
            check($sformatf("rdata%0d_hold", n), 32'(rd), 32'(last_rd[n]));
            if (n == 0 && q0.size() > 0 && q0[0].due < cyc) begin
              fail("rvalid0_missing"); void'(q0.pop_front());
            end
            if (n == 1 && q1.size() > 0 && q1[0].due < cyc) begin
              fail("rvalid1_missing"); void'(q1.pop_front());
            end
          end
        end
        p_req      = {bus.req1, bus.req0};
        p_ack      = {bus.ack1, bus.ack0};
        p_we       = {bus.we1, bus.we0};
        p_addr[0]  = bus.addr0;
        p_addr[1]  = bus.addr1;
        p_wdata[0] = bus.wdata0;
        p_wdata[1] = bus.wdata1;
      end
    end
  endtask

  // Present one request and hold it until acknowledged; returns at
  // posedge+1 of the ack cycle with req already dropped.
  task automatic do_req(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    req[n] = 1'b1; we[n] = w; addr[n] = a; wdata[n] = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = ack_of(n);
    end
    if (!got) fail($sformatf("ack%0d_timeout", n));
    req[n] = 1'b0;
  endtask

  task automatic wait_rv(input int n, output logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = rv_of(n);
    end
    if (!got) fail($sformatf("rvalid%0d_timeout", n));
    else d = rd_of(n);
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic rand_req(input int n, input int count);
    repeat (count) begin
      idle($urandom_range(0, 2));
      do_req(n, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end
  endtask

  logic [DW-1:0] rdv;
  int            acks0, acks1;

  initial begin
    req = '{default: 1'b0}; we = '{default: 1'b0};
    addr = '{default: '0}; wdata = '{default: '0};
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single read by requester 0: ack in cycle 1, data in cycle 3.
    do_req(1, 1'b1, 10'h012, 8'hA5);
    idle(2);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h012;
    @(posedge clk); #1;
    check("t1_ack0", {31'd0, bus.ack0}, 32'd1);
    check("t1_ram_address", 32'(bus.ram_address), 32'h012);
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("t1_rvalid0_early", {31'd0, bus.rvalid0}, 32'd0);
    @(posedge clk); #1;
    check("t1_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    check("t1_rdata0", 32'(bus.rdata0), 32'hA5);
    idle(2);

    // Requester 1 write then read of the top address.
    do_req(1, 1'b1, 10'h3FF, 8'h5C);
    check("t2_wren", {30'd0, bus.ram_wren, bus.ack1}, 32'd3);
    do_req(1, 1'b0, 10'h3FF, 8'h00);
    wait_rv(1, rdv);
    check("t2_rdata1", 32'(rdv), 32'h5C);
    idle(3);

    // Both requesters hold reads for 8 cycles: grants alternate 0,1,0,1...
    acks0 = 0; acks1 = 0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h012;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h3FF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("t3_first_grant_or_alt", {30'd0, bus.ack1, bus.ack0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      acks0 += int'(bus.ack0);
      acks1 += int'(bus.ack1);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    check("t3_acks0", 32'(acks0), 32'd4);
    check("t3_acks1", 32'(acks1), 32'd4);
    idle(4);

    // Read followed immediately by a write to the same address.
    do_req(0, 1'b1, 10'h040, 8'h33);
    idle(2);
    fork
      do_req(0, 1'b0, 10'h040, 8'h00);
      begin
        @(posedge clk); #1;
        do_req(1, 1'b1, 10'h040, 8'hFF);
      end
    join
    @(posedge clk); #1;
    check("t6_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
    check("t6_rdata0_old", 32'(bus.rdata0), 32'h33);
    do_req(1, 1'b0, 10'h040, 8'h00);
    wait_rv(1, rdv);
    check("t6_rdata1_new", 32'(rdv), 32'hFF);
    idle(3);

    // Reset in the cycle after a read ack: the read never returns.
    do_req(0, 1'b0, 10'h012, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_ctrl_in_reset", {29'd0, bus.ack0, bus.rvalid0, bus.ram_wren}, 32'd0);
    @(posedge clk); #1;
    check("t5_no_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);

    // Reset during a write's issue cycle cancels the write.
    do_req(1, 1'b1, 10'h012, 8'h77);
    rst_n = 1'b0;
    #1;
    check("t5_wren_cancel", {31'd0, bus.ram_wren}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    do_req(0, 1'b0, 10'h012, 8'h00);
    wait_rv(0, rdv);
    check("t5_write_cancelled", 32'(rdv), 32'hA5);
    idle(3);

    // Randomized traffic from both requesters on a small address window.
    fork
      rand_req(0, 150);
      rand_req(1, 150);
    join
    idle(6);
    check("drain_queues", 32'(q0.size() + q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
